// File: rtl/router_pkg.sv
// router_pkg: frame type codes, field offsets, frame builders and FSM states for the token router
package router_pkg;
    localparam logic [2:0] T_ACK   = 3'b000;
    localparam logic [2:0] T_DATA  = 3'b001;
    localparam logic [2:0] T_NACK  = 3'b011;
    localparam logic [2:0] T_TOKEN = 3'b111;
    localparam int MAXW = 256;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS} state_e;

    function automatic int type_off(input int aw, input int pw);
        return 2*aw + pw;
    endfunction

    function automatic int dest_off(input int aw, input int pw);
        return aw + pw;
    endfunction

    function automatic int src_off(input int pw);
        return pw;
    endfunction

    function automatic logic [MAXW-1:0] mk_frame(input logic [2:0] t, input logic [MAXW-1:0] dest,
                                                 input logic [MAXW-1:0] src, input logic [MAXW-1:0] payload,
                                                 input int aw, input int pw);
        return (MAXW'(t) << type_off(aw, pw)) | (dest << dest_off(aw, pw)) | (src << src_off(pw)) | payload;
    endfunction

    function automatic logic [MAXW-1:0] mk_resp(input logic [2:0] t, input logic [MAXW-1:0] dest,
                                                input logic [MAXW-1:0] src, input int aw, input int pw);
        return mk_frame(t, dest, src, '0, aw, pw);
    endfunction

    function automatic logic [MAXW-1:0] mk_token(input int aw, input int pw);
        return mk_frame(T_TOKEN, '0, '0, '0, aw, pw);
    endfunction
endpackage

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: synchronous circular-buffer FIFO with occupancy count, full and empty flags
module router_pkt_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 48
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [W-1:0]            din_i,
    output logic [W-1:0]            dout_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);
    localparam int PTW = $clog2(DEPTH);
    localparam int CW = PTW + 1;
    logic [W-1:0] mem_q [DEPTH];
    logic [PTW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic do_push, do_pop;
    assign full_o = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_pop = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o = mem_q[rp_q];
    assign count_o = cnt_q;
    // storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk_i)
        if (do_push) mem_q[wp_q] <= din_i;
    // pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/token_router_core_p.sv
// token_router_core_p: token-ring node core with TX FIFO, delivery register and NACK/timeout retransmission
module token_router_core_p
    import router_pkg::*;
#(
    parameter int AW = 4,
    parameter int PW = 44,
    parameter logic [AW-1:0] OUR_ADDR = '0,
    parameter int DEPTH = 4,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                    Clk_R,
    input  logic                    Rst,
    input  logic [3+2*AW+PW-1:0]    RX_Data,
    input  logic                    RX_Data_Valid,
    output logic                    RX_Data_Ready,
    output logic [3+2*AW+PW-1:0]    TX_Data,
    output logic                    TX_Data_Valid,
    input  logic                    TX_Data_Ready,
    input  logic [AW+PW-1:0]        Packet_From_Node,
    input  logic                    Packet_From_Node_Valid,
    output logic                    Core_Load_Ack,
    output logic [AW+PW-1:0]        Packet_To_Node,
    output logic                    Packet_To_Node_Valid,
    input  logic                    Packet_To_Node_Ready,
    output logic                    Drop_Pulse,
    output logic [$clog2(DEPTH):0]  Fifo_Count
);
    localparam int FW = 3 + 2*AW + PW;
    localparam int DO = dest_off(AW, PW);
    localparam int SO = src_off(PW);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);
    localparam logic [RW-1:0] MAXR = RW'(MAX_RETRY);

    state_e state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [RW-1:0] att_q, att_d;
    logic [FW-1:0] tx_q, tx_d;
    logic tx_v_q, tx_v_d;
    logic [AW+PW-1:0] dlv_q, dlv_d;
    logic dlv_v_q, dlv_v_d;
    logic drop_q, drop_d;
    logic alive_q;
    logic pop, push, resp, nack, f_full, f_empty, tx_free, rx_acc, dlv_free;
    logic [AW+PW-1:0] hd;
    logic [2:0] rt;
    logic [AW-1:0] rd, rs;
    logic [FW-1:0] data_fr;

    assign rt = RX_Data[DO+AW +: 3];
    assign rd = RX_Data[DO +: AW];
    assign rs = RX_Data[SO +: AW];
    assign tx_free = !tx_v_q || TX_Data_Ready;
    assign dlv_free = !dlv_v_q || Packet_To_Node_Ready;
    assign RX_Data_Ready = alive_q && (state_q == S_IDLE || state_q == S_WAIT) && tx_free;
    assign rx_acc = RX_Data_Valid && RX_Data_Ready;
    assign Core_Load_Ack = alive_q && (!f_full || pop);
    assign push = Packet_From_Node_Valid && Core_Load_Ack;
    assign data_fr = FW'(mk_frame(T_DATA, MAXW'(hd[PW +: AW]), MAXW'(OUR_ADDR), MAXW'(hd[PW-1:0]), AW, PW));
    assign TX_Data = tx_q;
    assign TX_Data_Valid = tx_v_q;
    assign Packet_To_Node = dlv_q;
    assign Packet_To_Node_Valid = dlv_v_q;
    assign Drop_Pulse = drop_q;

    router_pkt_fifo #(.DEPTH(DEPTH), .W(AW+PW)) u_fifo (
        .clk_i(Clk_R), .rst_i(Rst), .push_i(push), .pop_i(pop), .din_i(Packet_From_Node),
        .dout_o(hd), .count_o(Fifo_Count), .full_o(f_full), .empty_o(f_empty)
    );

    // RX dispatch, response/timeout handling and token release
    always_comb begin
        state_d = state_q;
        att_d = att_q;
        tmr_d = (state_q == S_WAIT && !tx_v_q && tmr_q != TMO) ? tmr_q + 1'b1 : tmr_q;
        tx_d = tx_q;
        tx_v_d = tx_v_q && !TX_Data_Ready;
        dlv_d = dlv_q;
        dlv_v_d = dlv_v_q && !Packet_To_Node_Ready;
        pop = 1'b0;
        drop_d = 1'b0;
        resp = 1'b0;
        nack = 1'b0;
        if (rx_acc) begin
            tx_v_d = 1'b1;
            tx_d = RX_Data;
            if (rt == T_DATA && rd == OUR_ADDR) begin
                if (dlv_free) begin
                    dlv_v_d = 1'b1;
                    dlv_d = {rs, RX_Data[PW-1:0]};
                end
                tx_d = FW'(mk_resp(dlv_free ? T_ACK : T_NACK, MAXW'(rs), MAXW'(OUR_ADDR), AW, PW));
            end else if ((rt == T_ACK || rt == T_NACK) && rd == OUR_ADDR && state_q == S_WAIT) begin
                resp = 1'b1;
                nack = rt == T_NACK;
                tx_v_d = 1'b0;
            end else if (rt == T_TOKEN) begin
                if (!f_empty) begin
                    tx_d = data_fr;
                    state_d = S_WAIT;
                    att_d = '0;
                    tmr_d = '0;
                end
            end else if (rt != T_DATA && rt != T_ACK && rt != T_NACK) begin
                tx_d = FW'(mk_resp(T_NACK, MAXW'(rs), MAXW'(OUR_ADDR), AW, PW));
            end
        end else if (state_q == S_WAIT && tmr_q == TMO && tx_free) begin
            resp = 1'b1;
            nack = 1'b1;
        end
        if (resp) begin
            if (!nack) begin
                pop = 1'b1;
                state_d = S_PASS;
            end else if (att_q < MAXR) begin
                att_d = att_q + 1'b1;
                tx_v_d = 1'b1;
                tx_d = data_fr;
                tmr_d = '0;
            end else begin
                pop = 1'b1;
                drop_d = 1'b1;
                state_d = S_PASS;
            end
        end
        if (state_q == S_PASS && tx_free) begin
            tx_v_d = 1'b1;
            tx_d = FW'(mk_token(AW, PW));
            state_d = S_IDLE;
        end
    end

    // state, TX, delivery and pulse registers; reset discards everything in flight
    always_ff @(posedge Clk_R or posedge Rst)
        if (Rst) begin
            state_q <= S_IDLE;
            att_q <= '0;
            tmr_q <= '0;
            tx_q <= '0;
            tx_v_q <= 1'b0;
            dlv_q <= '0;
            dlv_v_q <= 1'b0;
            drop_q <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            att_q <= att_d;
            tmr_q <= tmr_d;
            tx_q <= tx_d;
            tx_v_q <= tx_v_d;
            dlv_q <= dlv_d;
            dlv_v_q <= dlv_v_d;
            drop_q <= drop_d;
            alive_q <= 1'b1;
        end
endmodule
